clk_div_ctrl: RTL and testbench

Run/stop controller and safe reconfiguration front-end for the programmable time-base divider. It owns the divide counter. It accepts new divisor values through a valid/ready handshake and applies them only at a period boundary, so the divided clock never glitches. It produces the divided clock (half-period = divisor cycles of clk_in) plus a one-cycle tick strobe for downstream consumers.

---
 rtl/clk_div_ctrl.sv | 146 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Run/stop controller for the programmable time-base divider.
// Divisor updates land only on a terminal count, so clk_out never glitches.
`timescale 1ns/1ps
module clk_div_ctrl #(
  parameter int CNT_W       = 14,
  parameter int DEFAULT_DIV = 14000,
  parameter int MIN_DIV     = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;
  logic             r_err;

  state_t           w_eff;
  state_t           w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_div_n;
  logic [CNT_W-1:0] w_shadow_n;
  logic             w_pend_n;
  logic             w_clk_n;
  logic             w_tick_n;
  logic             w_err_n;
  logic             w_xfer;
  logic             w_bad;
  logic             w_acc;
  logic             w_tc;

  assign cfg_ready = (r_state == S_IDLE) || (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign clk_out   = r_clk;
  assign tick      = r_tick;
  assign cfg_err   = r_err;

  assign w_xfer = cfg_valid && cfg_ready;
  assign w_bad  = cfg_div < CNT_W'(MIN_DIV);
  assign w_acc  = w_xfer && !w_bad;
  assign w_tc   = r_cnt == (r_div - CNT_W'(1));

  // Re-enable during STOP behaves as the resumed state for that cycle.
  always_comb begin
    w_eff = r_state;
    if (r_state == S_STOP && enable) begin
      w_eff = r_pend ? S_PEND : S_RUN;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_div_n    = r_div;
    w_shadow_n = r_shadow;
    w_pend_n   = r_pend;
    w_clk_n    = r_clk;
    w_tick_n   = 1'b0;
    w_err_n    = w_xfer && w_bad;
    if (w_eff != S_IDLE) begin
      if (w_tc) begin
        w_cnt_n  = '0;
        w_clk_n  = ~r_clk;
        w_tick_n = 1'b1;
      end else begin
        w_cnt_n = r_cnt + CNT_W'(1);
      end
    end
    unique case (w_eff)
      S_IDLE: begin
        w_cnt_n = '0;
        w_clk_n = 1'b0;
        if (w_acc) w_div_n = cfg_div;
        if (enable) w_state_n = S_RUN;
      end
      S_RUN: begin
        w_state_n = S_RUN;
        if (w_acc) begin
          w_shadow_n = cfg_div;
          w_pend_n   = 1'b1;
          w_state_n  = S_PEND;
        end
        if (!enable) w_state_n = S_STOP;
      end
      S_PEND: begin
        w_state_n = S_PEND;
        if (w_tc) begin
          w_div_n   = r_shadow;
          w_pend_n  = 1'b0;
          w_state_n = S_RUN;
        end
        if (!enable) w_state_n = S_STOP;
      end
      S_STOP: begin
        if (w_tc && r_clk) begin
          w_clk_n   = 1'b0;
          w_state_n = S_IDLE;
          w_pend_n  = 1'b0;
          if (r_pend) w_div_n = r_shadow;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= CNT_W'(DEFAULT_DIV);
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_div    <= w_div_n;
      r_shadow <= w_shadow_n;
      r_pend   <= w_pend_n;
      r_clk    <= w_clk_n;
      r_tick   <= w_tick_n;
      r_err    <= w_err_n;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with a half-period countdown model.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int W   = 6;
  localparam int DEF = 4;
  localparam int MIN = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         tick;
  logic         busy;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W(W),
    .DEFAULT_DIV(DEF),
    .MIN_DIV(MIN)
  ) dut (
    .clk_in(clk),
    .reset(reset),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy)
  );

  typedef struct packed {
    logic c;
    logic t;
    logic e;
    logic r;
    logic b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   active   = 0;

  // Model: running/stopping/pending flags, cycles left in the half-period.
  bit m_run, m_stop, m_pend, m_clk;
  int m_div, m_new, m_left;

  task automatic step(input bit rst, input bit en,
                      input bit v, input int d);
    bit rdy, acc, tc, oldclk, pendb, tk, er;
    exp_t x;
    tk = 0;
    er = 0;
    reset     = rst;
    enable    = en;
    cfg_valid = v;
    cfg_div   = d[W-1:0];
    if (rst) begin
      m_run  = 0;
      m_stop = 0;
      m_pend = 0;
      m_clk  = 0;
      m_div  = DEF;
      m_left = 0;
    end else begin
      rdy = !m_run || (!m_pend && !m_stop);
      acc = v && rdy && d >= MIN;
      er  = v && rdy && d < MIN;
      if (!m_run) begin
        m_clk = 0;
        if (acc) m_div = d;
        if (en) begin
          m_run  = 1;
          m_left = m_div;
        end
      end else begin
        if (m_stop && en) m_stop = 0;
        pendb  = m_pend;
        oldclk = m_clk;
        m_left = m_left - 1;
        tc     = (m_left == 0);
        if (acc) begin
          m_new  = d;
          m_pend = 1;
        end
        if (tc) begin
          tk    = 1;
          m_clk = !m_clk;
          if (m_stop && oldclk) begin
            m_clk  = 0;
            m_run  = 0;
            m_stop = 0;
            if (m_pend) m_div = m_new;
            m_pend = 0;
          end else begin
            if (pendb && !m_stop) begin
              m_div  = m_new;
              m_pend = 0;
            end
            m_left = m_div;
          end
        end
        if (m_run && !en) m_stop = 1;
      end
    end
    x.c = m_clk;
    x.t = tk;
    x.e = er;
    x.r = !m_run || (!m_pend && !m_stop);
    x.b = m_run;
    q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {clk_out, tick, cfg_err, cfg_ready, busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d {clk,tick,err,rdy,busy} got=%b exp=%b",
                 cyc, a, e);
      end
    end else if (active) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty cyc=%0d got=none exp=entry", cyc);
    end
  end

  initial begin
    bit en;
    reset     = 1;
    enable    = 0;
    cfg_valid = 0;
    cfg_div   = '0;
    @(negedge clk);
    active = 1;
    repeat (3) step(1, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    repeat (12) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 1, 6);
    step(0, 1, 1, 7);
    repeat (30) step(0, 1, 0, 0);
    repeat (30) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    repeat (30) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 6);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (40) step(0, 1, 0, 0);
    step(0, 1, 1, 9);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    repeat (20) step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    step(0, 0, 1, 1);
    repeat (20) step(0, 1, 0, 0);
    step(0, 1, 1, 63);
    repeat (200) step(0, 1, 0, 0);
    en = 1;
    for (int i = 0; i < 5000; i++) begin
      int d;
      if ($urandom_range(0, 24) == 0) en = !en;
      if ($urandom_range(0, 60) == 0) d = 63;
      else if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1);
      else d = $urandom_range(2, 9);
      step($urandom_range(0, 499) == 0, en,
           $urandom_range(0, 5) == 0, d);
    end
    active = 0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
